// File: rtl/sysbus_pkg.sv
// sysbus_pkg: Sysbus tag encoding, target codes, line geometry and responder state encoding
package sysbus_pkg;
    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic       SYSBUS_WRITE  = 1'b0;
    localparam logic [3:0] SYSBUS_MEMORY = 4'h1;
    localparam int         TAG_RW_BIT    = 12;
    localparam int         TAG_TGT_MSB   = 11;
    localparam int         TAG_TGT_LSB   = 8;
    localparam int         LINE_BEATS    = 8;
    typedef enum logic [1:0] {IDLE, WAIT, RESP, WDATA} state_t;
endpackage

// File: rtl/sysbus_mem_responder_if.sv
// sysbus_mem_responder_if: Sysbus request/response channel bundle with initiator and responder views
interface sysbus_mem_responder_if #(
    parameter int DW = 64,
    parameter int TW = 13
) ();
    logic          reqcyc;
    logic [DW-1:0] req;
    logic [TW-1:0] reqtag;
    logic          reqack;
    logic          respcyc;
    logic [DW-1:0] resp;
    logic [TW-1:0] resptag;
    logic          respack;
    modport master (output reqcyc, req, reqtag, respack, input reqack, respcyc, resp, resptag);
    modport slave  (input reqcyc, req, reqtag, respack, output reqack, respcyc, resp, resptag);
endinterface

// File: rtl/sysbus_mem_array.sv
// sysbus_mem_array: word array with one synchronous write port and one asynchronous read port
module sysbus_mem_array #(
    parameter int AW = 16,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];
    // contents are deliberately not reset so preloaded data survives a bus reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: Sysbus memory-side responder serving 8-beat line reads and writes
module sysbus_mem_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int LINE_BEATS     = sysbus_pkg::LINE_BEATS,
    parameter int RESP_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    sysbus_mem_responder_if.slave     bus,
    input  logic                      init_we,
    input  logic [MEM_ADDR_WIDTH-1:0] init_addr,
    input  logic [BUS_DATA_WIDTH-1:0] init_data
);
    import sysbus_pkg::*;
    localparam int         LW   = MEM_ADDR_WIDTH - 3;
    localparam logic [2:0] LAST = 3'(LINE_BEATS - 1);
    state_t                    state, state_nx;
    logic [LW-1:0]             line;
    logic [2:0]                beat, rd_beat;
    logic [7:0]                lat;
    logic                      hit, hdr, wbeat, retire, present, we;
    logic [MEM_ADDR_WIDTH-1:0] waddr;
    logic [BUS_DATA_WIDTH-1:0] wdata, rdata;

    sysbus_mem_array #(.AW(MEM_ADDR_WIDTH), .DW(BUS_DATA_WIDTH)) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr ({line, rd_beat}),
        .rdata (rdata)
    );

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nx;
    end

    // transfer sequencing: header splits into read or write, each ends after the last beat
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = hdr ? (bus.reqtag[TAG_RW_BIT] == SYSBUS_READ ? WAIT : WDATA) : IDLE;
            WAIT:    state_nx = lat == 8'd1 ? RESP : WAIT;
            RESP:    state_nx = retire && beat == LAST ? IDLE : RESP;
            WDATA:   state_nx = wbeat && beat == LAST ? IDLE : WDATA;
            default: state_nx = IDLE;
        endcase
    end

    // handshake decode and array port steering; backdoor only owns the write port in IDLE
    always_comb begin
        hdr     = state == IDLE && bus.reqcyc;
        wbeat   = state == WDATA && bus.reqcyc;
        retire  = state == RESP && bus.respcyc && bus.respack;
        present = (state == WAIT && lat == 8'd1) || (retire && beat != LAST);
        rd_beat = state == WAIT ? 3'd0 : beat + 3'd1;
        we      = (wbeat && hit) || (state == IDLE && init_we);
        waddr   = state == WDATA ? {line, beat} : init_addr;
        wdata   = state == WDATA ? bus.req : init_data;
    end

    // registered bus outputs, header capture, latency and beat counters
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.reqack  <= 1'b0;
            bus.respcyc <= 1'b0;
            bus.resp    <= '0;
            bus.resptag <= '0;
            beat        <= '0;
            lat         <= '0;
            line        <= '0;
            hit         <= 1'b0;
        end else begin
            bus.reqack <= hdr || wbeat;
            if (hdr) begin
                line        <= bus.req[MEM_ADDR_WIDTH+2:6];
                hit         <= bus.reqtag[TAG_TGT_MSB:TAG_TGT_LSB] == SYSBUS_MEMORY;
                bus.resptag <= bus.reqtag;
                lat         <= 8'(RESP_LATENCY);
                beat        <= '0;
            end
            if (state == WAIT) lat <= lat - 8'd1;
            if (present) begin
                bus.respcyc <= 1'b1;
                bus.resp    <= hit ? rdata : '0;
            end else if (retire) begin
                bus.respcyc <= 1'b0;
            end
            if (retire || wbeat) beat <= beat + 3'd1;
        end
    end
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: scoreboard bench for the Sysbus memory responder
module tb_sysbus_mem_responder;
    localparam int L = 4;
    typedef struct packed {
        logic [63:0] d;
        logic [12:0] t;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_we;
    logic [15:0] init_addr;
    logic [63:0] init_data;
    int          checks = 0;
    int          errors = 0;
    beat_t       sb[$];

    always #5 clk = ~clk;

    sysbus_mem_responder_if #(.DW(64), .TW(13)) bus ();

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .MEM_ADDR_WIDTH(16),
        .LINE_BEATS(8), .RESP_LATENCY(L)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    // every presented beat must match the oldest outstanding expectation; retire pops it
    always @(negedge clk) begin
        #2;
        if (bus.respcyc) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got %h tag %h, none expected", bus.resp, bus.resptag);
            end else begin
                if (bus.resp !== sb[0].d || bus.resptag !== sb[0].t) begin
                    errors++;
                    $display("FAIL beat got %h tag %h expected %h tag %h", bus.resp, bus.resptag, sb[0].d, sb[0].t);
                end
                if (bus.respack) void'(sb.pop_front());
            end
        end
    end

    task automatic push_line(input logic [63:0] base, input logic [12:0] tag, input bit zero);
        for (int k = 0; k < 8; k++) sb.push_back('{d: zero ? 64'd0 : base + 64'(k), t: tag});
    endtask

    task automatic preload(input logic [15:0] word, input logic [63:0] val);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            init_we   = 1'b1;
            init_addr = word + 16'(k);
            init_data = val + 64'(k);
        end
        @(negedge clk);
        init_we = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] a, input logic [12:0] t, input bit tog,
                           output int ack_w, output int lat, output int span, output bit low_after);
        int n;
        bit ph;
        @(negedge clk);
        bus.reqcyc = 1'b1;
        bus.req    = a;
        bus.reqtag = t;
        ack_w = 0;
        do begin
            @(negedge clk);
            ack_w++;
        end while (!bus.reqack && ack_w < 50);
        bus.reqcyc = 1'b0;
        lat = 0;
        while (!bus.respcyc && lat < 600) begin
            @(negedge clk);
            lat++;
        end
        span = 0;
        n    = 0;
        ph   = 1'b0;
        while (n < 8 && span < 100) begin
            bus.respack = tog ? ~ph : 1'b1;
            if (bus.respack) n++;
            ph = ~ph;
            span++;
            @(negedge clk);
        end
        bus.respack = 1'b0;
        low_after = !bus.respcyc;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [12:0] t, input logic [63:0] d0,
                            input int gap, output int acks);
        acks = 0;
        @(negedge clk);
        bus.reqcyc = 1'b1;
        bus.req    = a;
        bus.reqtag = t;
        for (int k = 0; k <= 8; k++) begin
            int w = 0;
            do begin
                @(negedge clk);
                w++;
                if (bus.reqack) acks++;
            end while (!bus.reqack && w < 50);
            if (k < 8) begin
                if (k == gap) begin
                    bus.reqcyc = 1'b0;
                    @(negedge clk);
                    if (bus.reqack) acks++;
                    bus.reqcyc = 1'b1;
                end
                bus.req = d0 + 64'(k);
            end
        end
        bus.reqcyc = 1'b0;
        @(negedge clk);
        if (bus.reqack) acks++;
    endtask

    task automatic test_reset;
        reset       = 1'b1;
        bus.reqcyc  = 1'b0;
        bus.req     = '0;
        bus.reqtag  = '0;
        bus.respack = 1'b0;
        init_we     = 1'b0;
        init_addr   = '0;
        init_data   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks += 4;
        if (bus.reqack !== 1'b0) begin errors++; $display("FAIL reset_reqack got %b expected 0", bus.reqack); end
        if (bus.respcyc !== 1'b0) begin errors++; $display("FAIL reset_respcyc got %b expected 0", bus.respcyc); end
        if (bus.resp !== 64'd0) begin errors++; $display("FAIL reset_resp got %h expected 0", bus.resp); end
        if (bus.resptag !== 13'd0) begin errors++; $display("FAIL reset_resptag got %h expected 0", bus.resptag); end
    endtask

    task automatic test_read_hold;
        int aw, lat, span;
        bit low;
        preload(16'h0200, 64'h1000);
        push_line(64'h1000, 13'h1100, 1'b0);
        do_read(64'h1000, 13'h1100, 1'b0, aw, lat, span, low);
        checks += 5;
        if (aw != 1) begin errors++; $display("FAIL hold_ack_cycle got %0d expected 1", aw); end
        if (lat != L) begin errors++; $display("FAIL hold_latency got %0d expected %0d", lat, L); end
        if (span != 8) begin errors++; $display("FAIL hold_span got %0d expected 8", span); end
        if (!low) begin errors++; $display("FAIL hold_respcyc_low got 1 expected 0"); end
        if (sb.size() != 0) begin errors++; $display("FAIL hold_leftover got %0d expected 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_read_toggle;
        int aw, lat, span;
        bit low;
        push_line(64'h1000, 13'h1100, 1'b0);
        do_read(64'h1000, 13'h1100, 1'b1, aw, lat, span, low);
        checks += 3;
        if (span != 15) begin errors++; $display("FAIL toggle_span got %0d expected 15", span); end
        if (!low) begin errors++; $display("FAIL toggle_respcyc_low got 1 expected 0"); end
        if (sb.size() != 0) begin errors++; $display("FAIL toggle_leftover got %0d expected 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_write_gap;
        int acks, aw, lat, span;
        bit low;
        do_write(64'h2040, 13'h0100, 64'hA0, 3, acks);
        push_line(64'hA0, 13'h1100, 1'b0);
        do_read(64'h2048, 13'h1100, 1'b0, aw, lat, span, low);
        checks += 2;
        if (acks != 9) begin errors++; $display("FAIL write_acks got %0d expected 9", acks); end
        if (sb.size() != 0) begin errors++; $display("FAIL write_readback_leftover got %0d expected 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_wrap;
        int aw, lat, span;
        bit low;
        push_line(64'h1000, 13'h1107, 1'b0);
        do_read(64'h1_0000_1000, 13'h1107, 1'b0, aw, lat, span, low);
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL wrap_leftover got %0d expected 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_other_target;
        int acks, aw, lat, span;
        bit low;
        push_line(64'h0, 13'h1205, 1'b1);
        do_read(64'h1000, 13'h1205, 1'b0, aw, lat, span, low);
        do_write(64'h2040, 13'h0200, 64'hB0, -1, acks);
        push_line(64'hA0, 13'h1100, 1'b0);
        do_read(64'h2040, 13'h1100, 1'b0, aw, lat, span, low);
        checks += 2;
        if (acks != 9) begin errors++; $display("FAIL other_write_acks got %0d expected 9", acks); end
        if (sb.size() != 0) begin errors++; $display("FAIL other_leftover got %0d expected 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_reset_mid_read;
        int w, aw, lat, span;
        bit low;
        for (int k = 0; k < 4; k++) sb.push_back('{d: 64'h1000 + 64'(k), t: 13'h1100});
        @(negedge clk);
        bus.reqcyc = 1'b1;
        bus.req    = 64'h1000;
        bus.reqtag = 13'h1100;
        w = 0;
        do begin @(negedge clk); w++; end while (!bus.reqack && w < 50);
        bus.reqcyc = 1'b0;
        w = 0;
        while (!bus.respcyc && w < 600) begin @(negedge clk); w++; end
        repeat (3) begin
            bus.respack = 1'b1;
            @(negedge clk);
        end
        bus.respack = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks += 2;
        if (bus.respcyc !== 1'b0) begin errors++; $display("FAIL midreset_respcyc got %b expected 0", bus.respcyc); end
        if (sb.size() != 1) begin errors++; $display("FAIL midreset_beats got %0d left expected 1", sb.size()); end
        sb.delete();
        push_line(64'h1000, 13'h1100, 1'b0);
        do_read(64'h1000, 13'h1100, 1'b0, aw, lat, span, low);
        checks += 2;
        if (aw != 1) begin errors++; $display("FAIL midreset_idle_ack got %0d expected 1", aw); end
        if (sb.size() != 0) begin errors++; $display("FAIL midreset_fresh_leftover got %0d expected 0", sb.size()); end
        sb.delete();
    endtask

    initial begin
        test_reset;
        test_read_hold;
        test_read_toggle;
        test_write_gap;
        test_wrap;
        test_other_target;
        test_reset_mid_read;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sysbus_mem_responder.md
# sysbus_mem_responder

Memory-side responder for the Sysbus, the far end of the core's fetch/page-walk initiator. Accepts line requests on the request channel, returns 64-byte lines as eight 64-bit beats on the response channel, and absorbs 8-beat line writes into an internal word array. It is the bench's DRAM model and the reference responder for any future Sysbus initiator.

## Interface
- BUS_DATA_WIDTH, 64, data/address width of bus_req and bus_resp
- BUS_TAG_WIDTH, 13, tag width
- MEM_ADDR_WIDTH, 16, log2 of array depth in 64-bit words
- LINE_BEATS, 8, beats per line (fixed at 8; 64-byte line)
- RESP_LATENCY, 4, cycles from reqack to first read beat; legal range 1..255
- clk  in  1  sole clock, all logic on posedge
- reset  in  1  synchronous, active-high
- bus_reqcyc  in  1  request/write-data beat valid
- bus_req  in  BUS_DATA_WIDTH  byte address (header) or write data (beats)
- bus_reqtag  in  BUS_TAG_WIDTH  tag: [12] 1=READ 0=WRITE, [11:8] target, [7:0] id
- bus_reqack  out  1  one-cycle pulse per accepted header or write beat
- bus_respcyc  out  1  read beat valid
- bus_resp  out  BUS_DATA_WIDTH  read beat data
- bus_resptag  out  BUS_TAG_WIDTH  header tag echoed unchanged
- bus_respack  in  1  initiator accepts current beat
- init_we  in  1  backdoor preload write enable
- init_addr  in  MEM_ADDR_WIDTH  backdoor word index
- init_data  in  BUS_DATA_WIDTH  backdoor word data

## Operation
- States: IDLE, WAIT, RESP, WDATA.
- IDLE: bus_reqcyc high -> capture header. Word index = bus_req[MEM_ADDR_WIDTH+2:3]; line base = same with low 3 bits cleared; bits above ignored (address wraps modulo array). Tag[12]=1 -> WAIT; tag[12]=0 -> WDATA. reqack pulses next cycle.
- WAIT: down-counter loaded with RESP_LATENCY; reaching zero -> RESP with beat 0 presented.
- RESP: beat k data = mem[line_base+k], k ascending 0..7, read at presentation time. Beat retires on a cycle with respcyc && respack; next beat presented the following cycle. Beat 7 retired -> IDLE, respcyc low.
- WDATA: each cycle with bus_reqcyc high is a data beat k, written to mem[line_base+k], reqack pulsed next cycle; after beat 7 -> IDLE. Gaps (reqcyc low) stall without timeout.
- Target field != SYSBUS_MEMORY: read returns eight zero beats with tag echoed; write beats acked and discarded.
- Backdoor init_we honored only in IDLE; ignored otherwise.
- Request while not IDLE: not acked; initiator must hold reqcyc.

## Timing
- Reset: state IDLE, bus_reqack 0, bus_respcyc 0, bus_resp 0, bus_resptag 0, beat/latency counters 0. Array contents NOT reset.
- Reset mid-read or mid-write: abort next edge; partial write beats already stored remain.
- Header sampled edge N -> reqack high cycle N+1 only -> first beat valid cycle N+1+RESP_LATENCY.
- Respack held high: 8 beats on 8 consecutive cycles. Respack low: beat and data held stable.
- Last beat retired edge M -> respcyc low cycle M+1; new header accepted from edge M+1.
- Simultaneous header and init_we in IDLE: both take effect; header read sees init data only if beat is presented after the write edge.
- All outputs registered; no combinational path input->output.

## Structure
- sysbus_pkg: SYSBUS_READ=1, SYSBUS_WRITE=0, SYSBUS_MEMORY target code, tag field bit positions, state enum, LINE_BEATS constant; shared with the core.
- Sub-module sysbus_mem_array: 2^MEM_ADDR_WIDTH x BUS_DATA_WIDTH, one synchronous write port (muxed bus/backdoor), one asynchronous read port.

## Test plan
- Preload mem[0x200+k]=0x1000+k; read header addr 0x1000, tag 0x1100 -> reqack cycle N+1, beats 0x1000..0x1007 on cycles N+5..N+12, resptag 0x1100.
- Same read, respack toggling 1/0 -> 8 beats over 15 cycles, data stable while respack low, no beat lost or duplicated.
- Write header addr 0x2040 tag 0x0100 then beats 0xA0..0xA7 with one idle gap -> 9 reqack pulses; subsequent read of 0x2048 (same line) returns 0xA0..0xA7 from beat 0.
- Read address 0x1_0000_1000 with MEM_ADDR_WIDTH=16 -> same data as 0x1000 (wrap).
- Read with target 0x2 -> eight zero beats, tag echoed; write with target 0x2 -> acked, array unchanged.
- Reset asserted during beat 3 of a read -> respcyc 0 next cycle, state IDLE, fresh read returns full correct line.
